// File: rtl/gshare_predictor_if.sv
// -----------------------------------------------------------------------------
// gshare_predictor_if
// Bundles the fetch-side prediction port, the ALU-side resolve port and the
// statistics outputs of the gshare predictor.
//   master : pipeline side (drives stall, predict and resolve inputs)
//   slave  : predictor side (drives ready, prediction, mispredict, statistics)
// Signal names keep the i_/o_ prefixes as seen from the predictor.
// -----------------------------------------------------------------------------
interface gshare_predictor_if #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int GHR_SIZE      = 8,
    parameter int INDEX_WIDTH   = 10,
    parameter int STAT_WIDTH    = 32
);
    logic                     i_Stall;
    logic                     i_predict_valid;
    logic [ADDRESS_WIDTH-1:0] i_IMEM_address;
    logic                     o_ready;
    logic                     o_taken;
    logic [INDEX_WIDTH-1:0]   o_index;
    logic [GHR_SIZE-1:0]      o_ghr;
    logic                     i_ALU_isbranch;
    logic                     i_ALU_outcome;
    logic                     i_ALU_prediction;
    logic [INDEX_WIDTH-1:0]   i_ALU_index;
    logic [GHR_SIZE-1:0]      i_ALU_ghr;
    logic                     o_mispredict;
    logic [STAT_WIDTH-1:0]    o_branch_count;
    logic [STAT_WIDTH-1:0]    o_mispredict_count;

    modport master (
        output i_Stall, i_predict_valid, i_IMEM_address,
        output i_ALU_isbranch, i_ALU_outcome, i_ALU_prediction, i_ALU_index, i_ALU_ghr,
        input  o_ready, o_taken, o_index, o_ghr, o_mispredict,
        input  o_branch_count, o_mispredict_count
    );

    modport slave (
        input  i_Stall, i_predict_valid, i_IMEM_address,
        input  i_ALU_isbranch, i_ALU_outcome, i_ALU_prediction, i_ALU_index, i_ALU_ghr,
        output o_ready, o_taken, o_index, o_ghr, o_mispredict,
        output o_branch_count, o_mispredict_count
    );
endinterface

// File: rtl/gshare_predictor.sv
// -----------------------------------------------------------------------------
// gshare_predictor
// Parametrised gshare conditional-branch predictor for the fetch stage.
// Ports:
//   i_Clk     : clock, all state updates on the rising edge
//   i_Reset_n : asynchronous active-low reset
//   bus       : gshare_predictor_if.slave
//     fetch   : i_predict_valid, i_IMEM_address -> o_taken, o_index, o_ghr
//     resolve : i_ALU_isbranch/outcome/prediction/index/ghr -> o_mispredict
//     status  : o_ready, o_branch_count, o_mispredict_count; i_Stall
// After reset the pattern table is swept to weakly-taken, one entry per cycle,
// before the predictor reports ready. Predictions are combinational; the table
// index and history snapshot travel down the pipe so the resolve can update the
// exact entry and rebuild the history when the speculative path was wrong.
// -----------------------------------------------------------------------------
module gshare_predictor #(
    parameter int ADDRESS_WIDTH = 22,
    parameter int GHR_SIZE      = 8,
    parameter int INDEX_WIDTH   = 10,
    parameter int CTR_WIDTH     = 2,
    parameter int PC_LSB        = 0,
    parameter int STAT_WIDTH    = 32
) (
    input  logic               i_Clk,
    input  logic               i_Reset_n,
    gshare_predictor_if.slave  bus
);
    localparam int DEPTH = 1 << INDEX_WIDTH;
    localparam logic [CTR_WIDTH-1:0]   CTR_WEAK_TAKEN = {1'b1, {(CTR_WIDTH-1){1'b0}}};
    localparam logic [CTR_WIDTH-1:0]   CTR_MAX        = {CTR_WIDTH{1'b1}};
    localparam logic [CTR_WIDTH-1:0]   CTR_MIN        = {CTR_WIDTH{1'b0}};
    localparam logic [CTR_WIDTH-1:0]   CTR_ONE        = {{(CTR_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [INDEX_WIDTH-1:0] PTR_LAST       = {INDEX_WIDTH{1'b1}};
    localparam logic [INDEX_WIDTH-1:0] PTR_ONE        = {{(INDEX_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [STAT_WIDTH-1:0]  STAT_MAX       = {STAT_WIDTH{1'b1}};
    localparam logic [STAT_WIDTH-1:0]  STAT_ONE       = {{(STAT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [GHR_SIZE-1:0]    GHR_RESET      = {GHR_SIZE{1'b1}};

    typedef enum logic [0:0] {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    // Saturating up/down step of a pattern-table counter.
    function automatic logic [CTR_WIDTH-1:0] ctr_update(
        input logic [CTR_WIDTH-1:0] ctr,
        input logic                 up
    );
        logic [CTR_WIDTH-1:0] res;
        if (up) begin
            if (ctr == CTR_MAX) res = ctr;
            else                res = ctr + CTR_ONE;
        end else begin
            if (ctr == CTR_MIN) res = ctr;
            else                res = ctr - CTR_ONE;
        end
        return res;
    endfunction

    // Statistics increment that sticks at all ones.
    function automatic logic [STAT_WIDTH-1:0] stat_inc(input logic [STAT_WIDTH-1:0] cnt);
        logic [STAT_WIDTH-1:0] res;
        if (cnt == STAT_MAX) res = cnt;
        else                 res = cnt + STAT_ONE;
        return res;
    endfunction

    state_t                 state_r;
    state_t                 state_next_s;
    logic                   is_ready_s;
    logic [INDEX_WIDTH-1:0] init_ptr_r;
    logic [GHR_SIZE-1:0]    ghr_r;
    logic [GHR_SIZE-1:0]    ghr_next_s;
    logic [STAT_WIDTH-1:0]  branch_count_r;
    logic [STAT_WIDTH-1:0]  mispredict_count_r;
    logic [CTR_WIDTH-1:0]   table_r [0:DEPTH-1];

    logic [INDEX_WIDTH-1:0] index_s;
    logic [CTR_WIDTH-1:0]   rd_ctr_s;
    logic [CTR_WIDTH-1:0]   alu_ctr_s;
    logic                   predict_acc_s;
    logic                   resolve_acc_s;
    logic                   mispredict_s;
    logic                   wr_en_s;
    logic [INDEX_WIDTH-1:0] wr_addr_s;
    logic [CTR_WIDTH-1:0]   wr_data_s;

    // State register: the sweep restarts from entry 0 on every reset.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_r <= ST_INIT;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state logic: leave INIT once the last table entry is being written.
    always_comb begin
        state_next_s = state_r;
        is_ready_s   = 1'b0;
        case (state_r)
            ST_INIT: begin
                is_ready_s = 1'b0;
                if (init_ptr_r == PTR_LAST) state_next_s = ST_READY;
                else                        state_next_s = ST_INIT;
            end
            ST_READY: begin
                is_ready_s   = 1'b1;
                state_next_s = ST_READY;
            end
            default: begin
                is_ready_s   = 1'b0;
                state_next_s = ST_INIT;
            end
        endcase
    end

    // Prediction, acceptance, history and table write-port selection.
    always_comb begin
        index_s       = bus.i_IMEM_address[PC_LSB +: INDEX_WIDTH] ^ INDEX_WIDTH'(ghr_r);
        rd_ctr_s      = table_r[index_s];
        alu_ctr_s     = table_r[bus.i_ALU_index];
        predict_acc_s = is_ready_s & bus.i_predict_valid & ~bus.i_Stall;
        resolve_acc_s = is_ready_s & bus.i_ALU_isbranch & ~bus.i_Stall;
        mispredict_s  = resolve_acc_s & (bus.i_ALU_outcome != bus.i_ALU_prediction);
        ghr_next_s    = ghr_r;
        wr_en_s       = 1'b0;
        wr_addr_s     = init_ptr_r;
        wr_data_s     = CTR_WEAK_TAKEN;

        // Repair wins over the speculative shift; the pipeline flushes that fetch.
        if (mispredict_s) begin
            ghr_next_s = {bus.i_ALU_ghr[GHR_SIZE-2:0], bus.i_ALU_outcome};
        end else if (predict_acc_s) begin
            ghr_next_s = {ghr_r[GHR_SIZE-2:0], rd_ctr_s[CTR_WIDTH-1]};
        end else begin
            ghr_next_s = ghr_r;
        end

        // One write port: the sweep owns it in INIT, accepted resolves in READY.
        if (!is_ready_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = init_ptr_r;
            wr_data_s = CTR_WEAK_TAKEN;
        end else if (resolve_acc_s) begin
            wr_en_s   = 1'b1;
            wr_addr_s = bus.i_ALU_index;
            wr_data_s = ctr_update(alu_ctr_s, bus.i_ALU_outcome);
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = init_ptr_r;
            wr_data_s = CTR_WEAK_TAKEN;
        end
    end

    // Sweep pointer, global history and statistics counters.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            init_ptr_r         <= {INDEX_WIDTH{1'b0}};
            ghr_r              <= GHR_RESET;
            branch_count_r     <= {STAT_WIDTH{1'b0}};
            mispredict_count_r <= {STAT_WIDTH{1'b0}};
        end else begin
            if (!is_ready_s) begin
                init_ptr_r <= init_ptr_r + PTR_ONE;
            end
            ghr_r <= ghr_next_s;
            if (resolve_acc_s) begin
                branch_count_r <= stat_inc(branch_count_r);
            end
            if (mispredict_s) begin
                mispredict_count_r <= stat_inc(mispredict_count_r);
            end
        end
    end

    // Pattern table storage; contents are rebuilt by the sweep, so no reset.
    always_ff @(posedge i_Clk) begin
        if (wr_en_s) begin
            table_r[wr_addr_s] <= wr_data_s;
        end
    end

    assign bus.o_ready            = is_ready_s;
    assign bus.o_taken            = is_ready_s & rd_ctr_s[CTR_WIDTH-1];
    assign bus.o_index            = index_s;
    assign bus.o_ghr              = ghr_r;
    assign bus.o_mispredict       = mispredict_s;
    assign bus.o_branch_count     = branch_count_r;
    assign bus.o_mispredict_count = mispredict_count_r;

endmodule
